sme_memory_reader: RTL and testbench

Read-side master for the Sensor Manager memory port. It sits on input side 1 of the Sensor Manager memory mux and drives that mux's Select through BusyOut. On a start pulse it reads a block of 18-bit words from the shared sensor memory, from a start address for a word count. It absorbs the RAM's one-cycle read latency and streams the words to a host consumer over a valid/ready handshake with back-pressure.

---
 rtl/sme_mem_pkg.sv | 14 +
 rtl/sme_read_fifo.sv | 71 +++++++
 rtl/sme_memory_reader.sv | 120 ++++++++++++
 tb/tb_sme_memory_reader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sme_mem_pkg.sv
// Shared definitions for the Sensor Manager memory port: default widths and
// the reader FSM state encoding.
package sme_mem_pkg;

    localparam int SME_ADDR_WIDTH = 10;
    localparam int SME_DATA_WIDTH = 18;

    typedef logic [1:0] sme_rd_state_t;

    localparam sme_rd_state_t ST_IDLE  = 2'd0;
    localparam sme_rd_state_t ST_READ  = 2'd1;
    localparam sme_rd_state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/sme_read_fifo.sv
// Output buffer for the memory reader: power-of-two FIFO with flush,
// occupancy count and a registered head word.
module sme_read_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 18,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q;
    logic [CW-1:0] count_q, count_d, after_pop;
    logic [DW-1:0] head_q, head_d;
    logic          do_pop;

    assign do_pop = pop_i && (count_q != '0);

    // Head register looks ahead to the entry that will be at the front after
    // this cycle's pop/push, so DataOut is a flop rather than a RAM read mux.
    always_comb begin
        after_pop = count_q - CW'(do_pop);
        rd_ptr_d  = rd_ptr_q + AW'(do_pop);
        count_d   = after_pop + CW'(push_i);
        head_d    = head_q;
        if (after_pop != '0)
            head_d = mem_q[rd_ptr_d];
        else if (push_i)
            head_d = wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (push_i)
            mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_q + AW'(push_i);
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head_o  = head_q;
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !flush_i && !do_pop && count_q == CW'(DEPTH)));

endmodule

// File: rtl/sme_memory_reader.sv
// Read-side master for the Sensor Manager memory port: reads a block of words
// and streams them to the host over valid/ready, hiding the RAM's 1-cycle latency.
module sme_memory_reader
    import sme_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = SME_ADDR_WIDTH,
    parameter int DATA_WIDTH = SME_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  ClockIn,
    input  logic                  ResetIn_n,
    input  logic                  StartIn,
    input  logic [ADDR_WIDTH-1:0] StartAddressIn,
    input  logic [ADDR_WIDTH:0]   WordCountIn,
    input  logic                  AbortIn,
    output logic                  BusyOut,
    output logic                  DoneOut,
    output logic [ADDR_WIDTH-1:0] ReadAddressOut,
    output logic                  ReadEnableOut,
    output logic                  ReadClockOut,
    input  logic [DATA_WIDTH-1:0] DataFromMemoryIn,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  DataValidOut,
    input  logic                  DataReadyIn
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int NW = CW + 1;

    sme_rd_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d, rem_base;
    logic                  rden_q, rden_d, ret_q, ret_d, done_q, done_d;
    logic                  start_go, abort_go, pop, room, last_pop;
    logic [CW-1:0]         occ;
    logic [NW-1:0]         occ_next;

    assign abort_go = AbortIn && (state_q != ST_IDLE);
    assign start_go = StartIn && !AbortIn && (state_q == ST_IDLE);
    assign pop      = DataValidOut && DataReadyIn;
    assign last_pop = (state_q == ST_DRAIN) && pop && (occ == CW'(1)) && !ret_q;

    // Next cycle holds occ_next buffered words plus the read issued now; a new
    // issue is allowed only if that total plus one still fits in the buffer.
    assign occ_next = NW'(occ) + NW'(ret_q) - NW'(pop);
    assign room     = (occ_next + NW'(rden_q)) < NW'(FIFO_DEPTH);
    assign ret_d    = rden_q && !abort_go;

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        rem_base = rem_q;
        addr_d   = rden_q ? addr_q + ADDR_WIDTH'(1) : addr_q;
        if (start_go) begin
            rem_base = WordCountIn;
            addr_d   = StartAddressIn;
        end
        case (state_q)
            ST_IDLE:
                if (start_go) begin
                    if (WordCountIn != '0) state_d = ST_READ;
                    else                   done_d  = 1'b1;
                end
            ST_READ:
                if (rden_q && rem_q == '0) state_d = ST_DRAIN;
            ST_DRAIN:
                if (last_pop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            default: state_d = ST_IDLE;
        endcase
        if (abort_go) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end
        rden_d = (state_d == ST_READ) && (rem_base != '0) && room;
        rem_d  = rem_base - (ADDR_WIDTH+1)'(rden_d);
    end

    always_ff @(posedge ClockIn or negedge ResetIn_n) begin
        if (!ResetIn_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            rden_q  <= 1'b0;
            ret_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            rden_q  <= rden_d;
            ret_q   <= ret_d;
            done_q  <= done_d;
        end
    end

    sme_read_fifo #(
        .DEPTH(FIFO_DEPTH),
        .DW   (DATA_WIDTH)
    ) u_fifo (
        .clk_i  (ClockIn),
        .rst_ni (ResetIn_n),
        .flush_i(abort_go),
        .push_i (ret_q),
        .wdata_i(DataFromMemoryIn),
        .pop_i  (pop),
        .head_o (DataOut),
        .valid_o(DataValidOut),
        .count_o(occ)
    );

    assign BusyOut        = (state_q != ST_IDLE);
    assign DoneOut        = done_q;
    assign ReadAddressOut = addr_q;
    assign ReadEnableOut  = rden_q;
    assign ReadClockOut   = ClockIn;

endmodule

// File: tb/tb_sme_memory_reader.sv
// Scoreboard bench for sme_memory_reader with a 1-cycle-latency memory model.
module tb_sme_memory_reader;

    localparam int AW = 10;
    localparam int DW = 18;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, ready = 1'b1;
    logic [AW-1:0] saddr = '0;
    logic [AW:0]   wcnt = '0;
    logic          busy, done, re, rclk, valid;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata = '0, dout;

    int checks = 0, failures = 0, cyc = 0;
    int re_cnt, acc, done_cnt, first_re, last_re, first_v, last_v, done_cyc, issued, max_out;
    logic busy_seen, busy_at_done, tog = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] addr_log[$];

    sme_memory_reader dut (
        .ClockIn(clk), .ResetIn_n(rst_n), .StartIn(start), .StartAddressIn(saddr),
        .WordCountIn(wcnt), .AbortIn(abort), .BusyOut(busy), .DoneOut(done),
        .ReadAddressOut(raddr), .ReadEnableOut(re), .ReadClockOut(rclk),
        .DataFromMemoryIn(rdata), .DataOut(dout), .DataValidOut(valid), .DataReadyIn(ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return {8'hC3, a};
    endfunction

    always @(posedge rclk) if (re) rdata <= memf(raddr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: event recorder plus scoreboard pop on every accepted word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (re) begin
                issued++; re_cnt++;
                addr_log.push_back(raddr);
                if (first_re < 0) first_re = cyc;
                last_re = cyc;
            end
            if (issued - acc > max_out) max_out = issued - acc;
            if (busy) busy_seen = 1'b1;
            if (done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_word: got %0h expected none", dout);
                end else
                    chk("data", dout, exp_q.pop_front());
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                acc++;
            end
        end
    end

    // Ready pattern 1,0,0,1 while tog is set.
    int ph = 0;
    logic [3:0] pat = 4'b1001;
    always @(posedge clk) if (tog) begin #1; ready = pat[ph]; ph = (ph + 1) % 4; end

    task automatic clear();
        re_cnt = 0; acc = 0; done_cnt = 0; issued = 0; max_out = 0;
        first_re = -1; last_re = -1; first_v = -1; last_v = -1; done_cyc = -1;
        busy_seen = 1'b0; busy_at_done = 1'b1;
        exp_q.delete(); addr_log.delete();
    endtask

    task automatic go(input logic [AW-1:0] a, input int n, output int s);
        @(posedge clk); #1;
        start = 1'b1; saddr = a; wcnt = n[AW:0]; s = cyc;
        for (int i = 0; i < n; i++) exp_q.push_back(memf(a + AW'(i)));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0, k;
        d0 = done_cnt; k = 0;
        while (done_cnt == d0 && k < budget) begin @(negedge clk); #1; k++; end
        if (done_cnt == d0) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got no DoneOut expected DoneOut within %0d cycles", name, budget);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic [AW-1:0] ea [4];
        clear();
        #2;
        chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
        chk("rst_re", re, 0);       chk("rst_addr", raddr, 0);
        chk("rst_dout", dout, 0);   chk("rst_valid", valid, 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Basic block, ready held high
        clear(); go(10'h010, 4, s); wait_done("t1", 40); idle(3);
        chk("t1_first_re", first_re, s + 1);
        chk("t1_re_cnt", re_cnt, 4);
        chk("t1_first_valid", first_v, s + 3);
        chk("t1_last_valid", last_v, s + 6);
        chk("t1_done_cyc", done_cyc, s + 7);
        chk("t1_busy_at_done", busy_at_done, 0);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_accepted", acc, 4);

        // Address wrap
        clear(); go(10'h3FE, 4, s); wait_done("t2", 40); idle(2);
        ea = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        chk("t2_addr_cnt", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("t2_addr", addr_log[i], ea[i]);
        chk("t2_accepted", acc, 4);

        // Back-pressure
        clear(); tog = 1'b1; go(10'h040, 16, s); wait_done("t3", 300);
        tog = 1'b0; ready = 1'b1; idle(2);
        chk("t3_accepted", acc, 16);
        chk("t3_leftover", exp_q.size(), 0);
        chk("t3_re_cnt", re_cnt, 16);
        chk("t3_outstanding_le4", max_out <= 4, 1);
        chk("t3_issue_stalled", (last_re - first_re + 1) > 16, 1);

        // Zero-length request
        clear(); go(10'h000, 0, s); idle(4);
        chk("t4_done_cyc", done_cyc, s + 1);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_re_cnt", re_cnt, 0);
        chk("t4_busy_seen", busy_seen, 0);

        // Abort after three words, then a fresh one-word block
        clear(); go(10'h080, 8, s);
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (acc >= 3) break;
        end
        abort = 1'b1; ready = 1'b0;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        chk("t5_busy_after_abort", busy, 0);
        chk("t5_valid_after_abort", valid, 0);
        exp_q.delete(); ready = 1'b1; idle(5);
        chk("t5_no_done", done_cnt, 0);
        chk("t5_accepted", acc, 3);
        clear(); go(10'h100, 1, s); wait_done("t5b", 20); idle(3);
        chk("t5b_accepted", acc, 1);
        chk("t5b_leftover", exp_q.size(), 0);

        // Reset mid-transfer with an ignored start
        clear(); go(10'h180, 8, s);
        @(posedge clk); #1;
        start = 1'b1; saddr = 10'h200; wcnt = 11'd2;
        @(posedge clk); #1; start = 1'b0;
        chk("t6_busy_before_rst", busy, 1);
        @(posedge clk); #3; rst_n = 1'b0; #1;
        chk("t6_rst_busy", busy, 0);  chk("t6_rst_done", done, 0);
        chk("t6_rst_re", re, 0);      chk("t6_rst_addr", raddr, 0);
        chk("t6_rst_dout", dout, 0);  chk("t6_rst_valid", valid, 0);
        @(posedge clk); #1; rst_n = 1'b1; clear(); idle(20);
        chk("t6_no_reads", re_cnt, 0);
        chk("t6_no_words", acc, 0);
        chk("t6_no_busy", busy_seen, 0);
        chk("t6_no_done", done_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
